// File: rtl/snake_pkg.sv
// Shared constants and types for the snake body engine and its helpers.
package snake_pkg;

  localparam int COORD_W = 3;
  localparam int GRID_N  = 8;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MOVE  = 2'd2,
    DEAD  = 2'd3
  } state_e;

endpackage

// File: rtl/snake_next_cell.sv
// Combinational neighbour-cell calculator on the 8x8 torus: one step from
// (x,y) in direction dir, wrapping 7->0 and 0->7 on either axis.
module snake_next_cell
  import snake_pkg::*;
(
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [1:0]         dir_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);

  // Coordinates are exactly 3 bits wide, so natural overflow is the wrap.
  always_comb begin
    x_o = x_i;
    y_o = y_i;
    case (dir_i)
      DIR_UP:    y_o = y_i - 1'b1;
      DIR_RIGHT: x_o = x_i + 1'b1;
      DIR_DOWN:  y_o = y_i + 1'b1;
      DIR_LEFT:  x_o = x_i - 1'b1;
      default:   x_o = x_i;
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: keeps the body as a ring buffer of segments plus a
// registered 8x8 occupancy bitmap, proposes the next head cell to the
// collision detector, then commits the move, grows, or dies.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 3,
  parameter int INIT_Y   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step,
  input  logic [1:0]                 dir_in,
  input  logic                       grow,
  input  logic                       restart,
  input  logic                       collide_in,
  output logic [COORD_W-1:0]         next_x,
  output logic [COORD_W-1:0]         next_y,
  output logic                       check_valid,
  output logic [GRID_N-1:0]          row1,
  output logic [GRID_N-1:0]          row2,
  output logic [GRID_N-1:0]          row3,
  output logic [GRID_N-1:0]          row4,
  output logic [GRID_N-1:0]          row5,
  output logic [GRID_N-1:0]          row6,
  output logic [GRID_N-1:0]          row7,
  output logic [GRID_N-1:0]          row8,
  output logic [COORD_W-1:0]         head_x,
  output logic [COORD_W-1:0]         head_y,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       step_done,
  output logic                       dead
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = PTR_W + 1;

  // Start image: segment k of the ring holds body cell (INIT_LEN-1-k), so the
  // tail sits at slot 0 and the head at slot INIT_LEN-1.
  function automatic logic [COORD_W-1:0] init_seg_x(int k);
    return COORD_W'(INIT_X - (INIT_LEN - 1 - k));
  endfunction

  function automatic logic [GRID_N-1:0] init_row(int y);
    logic [GRID_N-1:0] r;
    r = '0;
    if (y == INIT_Y) begin
      for (int i = 0; i < INIT_LEN; i++) begin
        r[COORD_W'(GRID_N - 1 - INIT_X + i)] = 1'b1;
      end
    end
    return r;
  endfunction

  // A request for the exact reverse of the current heading is ignored.
  function automatic logic [1:0] opposite_dir(logic [1:0] d);
    logic [1:0] o;
    case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_RIGHT: o = DIR_LEFT;
      DIR_DOWN:  o = DIR_UP;
      default:   o = DIR_RIGHT;
    endcase
    return o;
  endfunction

  state_e               state_q;
  logic [1:0]           cur_dir_q;
  logic                 grow_pend_q;
  logic [COORD_W-1:0]   nx_q, ny_q;
  logic [COORD_W-1:0]   head_x_q, head_y_q;
  logic [PTR_W-1:0]     head_ptr_q, tail_ptr_q;
  logic [LEN_W-1:0]     len_q;
  logic                 check_valid_q, step_done_q, dead_q;
  logic [COORD_W-1:0]   seg_x_q [MAX_LEN];
  logic [COORD_W-1:0]   seg_y_q [MAX_LEN];
  logic [GRID_N-1:0]    grid_q  [GRID_N];

  logic [1:0]           dir_d;
  logic [COORD_W-1:0]   cand_x, cand_y;
  logic                 commit;
  logic                 do_grow;
  logic [PTR_W-1:0]     head_ptr_nxt;
  logic [COORD_W-1:0]   tail_x, tail_y;

  assign dir_d        = (dir_in == opposite_dir(cur_dir_q)) ? cur_dir_q : dir_in;
  assign commit       = (state_q == CHECK) && !collide_in;
  assign do_grow      = grow_pend_q && (len_q < LEN_W'(MAX_LEN));
  assign head_ptr_nxt = head_ptr_q + 1'b1;
  assign tail_x       = seg_x_q[tail_ptr_q];
  assign tail_y       = seg_y_q[tail_ptr_q];

  snake_next_cell u_next_cell (
    .x_i   (head_x_q),
    .y_i   (head_y_q),
    .dir_i (dir_d),
    .x_o   (cand_x),
    .y_o   (cand_y)
  );

  // Game-step FSM. The commit is registered on leaving CHECK, so the new
  // bitmap, head and step_done are all visible during the single MOVE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_dir_q     <= DIR_RIGHT;
      grow_pend_q   <= 1'b0;
      nx_q          <= COORD_W'(INIT_X);
      ny_q          <= COORD_W'(INIT_Y);
      head_x_q      <= COORD_W'(INIT_X);
      head_y_q      <= COORD_W'(INIT_Y);
      head_ptr_q    <= PTR_W'(INIT_LEN - 1);
      tail_ptr_q    <= '0;
      len_q         <= LEN_W'(INIT_LEN);
      check_valid_q <= 1'b0;
      step_done_q   <= 1'b0;
      dead_q        <= 1'b0;
    end else if (restart) begin
      state_q       <= IDLE;
      cur_dir_q     <= DIR_RIGHT;
      grow_pend_q   <= 1'b0;
      nx_q          <= COORD_W'(INIT_X);
      ny_q          <= COORD_W'(INIT_Y);
      head_x_q      <= COORD_W'(INIT_X);
      head_y_q      <= COORD_W'(INIT_Y);
      head_ptr_q    <= PTR_W'(INIT_LEN - 1);
      tail_ptr_q    <= '0;
      len_q         <= LEN_W'(INIT_LEN);
      check_valid_q <= 1'b0;
      step_done_q   <= 1'b0;
      dead_q        <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (step) begin
            grow_pend_q   <= grow;
            cur_dir_q     <= dir_d;
            nx_q          <= cand_x;
            ny_q          <= cand_y;
            check_valid_q <= 1'b1;
            state_q       <= CHECK;
          end
        end
        CHECK: begin
          check_valid_q <= 1'b0;
          if (collide_in) begin
            dead_q  <= 1'b1;
            state_q <= DEAD;
          end else begin
            head_x_q    <= nx_q;
            head_y_q    <= ny_q;
            head_ptr_q  <= head_ptr_nxt;
            step_done_q <= 1'b1;
            state_q     <= MOVE;
            if (do_grow) begin
              len_q <= len_q + 1'b1;
            end else begin
              tail_ptr_q <= tail_ptr_q + 1'b1;
            end
          end
        end
        MOVE: begin
          state_q <= IDLE;
        end
        DEAD: begin
          state_q <= DEAD;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Segment ring: reload the start image, otherwise append the new head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[PTR_W'(k)] <= init_seg_x(k);
        seg_y_q[PTR_W'(k)] <= COORD_W'(INIT_Y);
      end
    end else if (restart) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x_q[PTR_W'(k)] <= init_seg_x(k);
        seg_y_q[PTR_W'(k)] <= COORD_W'(INIT_Y);
      end
    end else if (commit) begin
      seg_x_q[head_ptr_nxt] <= nx_q;
      seg_y_q[head_ptr_nxt] <= ny_q;
    end
  end

  // Occupancy bitmap: bit (7-x) of row y, i.e. index ~x. The tail is cleared
  // before the head is set so the head always wins if they ever coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int y = 0; y < GRID_N; y++) begin
        grid_q[COORD_W'(y)] <= init_row(y);
      end
    end else if (restart) begin
      for (int y = 0; y < GRID_N; y++) begin
        grid_q[COORD_W'(y)] <= init_row(y);
      end
    end else if (commit) begin
      if (!do_grow) begin
        grid_q[tail_y][~tail_x] <= 1'b0;
      end
      grid_q[ny_q][~nx_q] <= 1'b1;
    end
  end

  assign next_x      = nx_q;
  assign next_y      = ny_q;
  assign check_valid = check_valid_q;
  assign head_x      = head_x_q;
  assign head_y      = head_y_q;
  assign length      = len_q;
  assign step_done   = step_done_q;
  assign dead        = dead_q;
  assign row1        = grid_q[0];
  assign row2        = grid_q[1];
  assign row3        = grid_q[2];
  assign row4        = grid_q[3];
  assign row5        = grid_q[4];
  assign row6        = grid_q[5];
  assign row7        = grid_q[6];
  assign row8        = grid_q[7];

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus a randomized walk
// checked against a queue-based model of the snake body.
module tb_snake_body_engine;

  localparam int MAX_LEN  = 16;
  localparam int INIT_LEN = 3;
  localparam int INIT_X   = 3;
  localparam int INIT_Y   = 3;
  localparam logic [63:0] RESET_MAP = 64'h0000_0000_7000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic [1:0] dir_in = 2'b01;
  logic       grow = 1'b0;
  logic       restart = 1'b0;
  logic       collide_in = 1'b0;
  logic [2:0] next_x, next_y, head_x, head_y;
  logic       check_valid, step_done, dead;
  logic [7:0] row1, row2, row3, row4, row5, row6, row7, row8;
  logic [4:0] length;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_body_engine #(
    .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .dir_in(dir_in), .grow(grow),
    .restart(restart), .collide_in(collide_in), .next_x(next_x), .next_y(next_y),
    .check_valid(check_valid), .row1(row1), .row2(row2), .row3(row3), .row4(row4),
    .row5(row5), .row6(row6), .row7(row7), .row8(row8), .head_x(head_x),
    .head_y(head_y), .length(length), .step_done(step_done), .dead(dead)
  );

  wire [63:0] obs_map = {row8, row7, row6, row5, row4, row3, row2, row1};

  // Reference model: body as a list of cells, head first.
  int   m_bx[$];
  int   m_by[$];
  int   m_dir;
  int   m_nx, m_ny;

  function automatic void model_reset();
    m_bx.delete();
    m_by.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      m_bx.push_back((INIT_X - i + 8) % 8);
      m_by.push_back(INIT_Y);
    end
    m_dir = 1;
  endfunction

  function automatic logic [63:0] model_map();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < m_bx.size(); i++) m[m_by[i] * 8 + (7 - m_bx[i])] = 1'b1;
    return m;
  endfunction

  function automatic void model_propose(int d);
    bit reverse;
    reverse = (m_dir == 0 && d == 2) || (m_dir == 2 && d == 0) ||
              (m_dir == 1 && d == 3) || (m_dir == 3 && d == 1);
    if (!reverse) m_dir = d;
    m_nx = m_bx[0];
    m_ny = m_by[0];
    if (m_dir == 0) m_ny = (m_ny + 7) % 8;
    if (m_dir == 1) m_nx = (m_nx + 1) % 8;
    if (m_dir == 2) m_ny = (m_ny + 1) % 8;
    if (m_dir == 3) m_nx = (m_nx + 7) % 8;
  endfunction

  function automatic bit model_hits(int x, int y);
    for (int i = 0; i < m_bx.size(); i++) if (m_bx[i] == x && m_by[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_commit(bit g);
    bit keep;
    keep = g && (m_bx.size() < MAX_LEN);
    m_bx.push_front(m_nx);
    m_by.push_front(m_ny);
    if (!keep) begin
      void'(m_bx.pop_back());
      void'(m_by.pop_back());
    end
  endfunction

  // Observations captured by drive_step.
  logic        o_cv1, o_cv2, o_done, o_done2, o_dead;
  logic [2:0]  o_nx, o_ny, o_hx, o_hy;
  logic [4:0]  o_len;
  logic [63:0] o_map_chk, o_map, e_pre_map;
  bit          e_collide;

  // One game step: drive step, play the detector, capture outputs, update model.
  task automatic drive_step(input int d, input bit g, input bit force_c);
    e_pre_map = model_map();
    model_propose(d);
    e_collide = force_c || model_hits(m_nx, m_ny);
    @(negedge clk);
    step = 1'b1; dir_in = 2'(d); grow = g;
    @(posedge clk); #1;
    step = 1'b0; grow = 1'b0;
    o_cv1 = check_valid; o_nx = next_x; o_ny = next_y; o_map_chk = obs_map;
    collide_in = e_collide;
    @(posedge clk); #1;
    collide_in = 1'b0;
    o_done = step_done; o_dead = dead; o_cv2 = check_valid; o_map = obs_map;
    o_hx = head_x; o_hy = head_y; o_len = length;
    @(posedge clk); #1;
    o_done2 = step_done;
    if (!e_collide) model_commit(g);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (obs_map !== RESET_MAP) begin errors++; $display("FAIL reset_map got %h want %h", obs_map, RESET_MAP); end
    checks++; if (length !== 5'd3) begin errors++; $display("FAIL reset_len got %0d want 3", length); end
    checks++; if ({head_x, head_y} !== {3'd3, 3'd3}) begin errors++; $display("FAIL reset_head got (%0d,%0d) want (3,3)", head_x, head_y); end
    checks++; if ({dead, check_valid, step_done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {dead, check_valid, step_done}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({next_x, next_y} !== {3'd3, 3'd3}) begin errors++; $display("FAIL reset_next got (%0d,%0d) want (3,3)", next_x, next_y); end
    model_reset();
  endtask

  task automatic test_restart();
    @(negedge clk); restart = 1'b1;
    @(posedge clk); #1; restart = 1'b0;
    model_reset();
    checks++; if (obs_map !== RESET_MAP) begin errors++; $display("FAIL restart_map got %h want %h", obs_map, RESET_MAP); end
    checks++; if ({dead, check_valid, length, head_x, head_y} !== {2'b00, 5'd3, 3'd3, 3'd3}) begin
      errors++; $display("FAIL restart_state got dead=%b cv=%b len=%0d head=(%0d,%0d) want 0 0 3 (3,3)", dead, check_valid, length, head_x, head_y);
    end
  endtask

  task automatic test_move_right();
    drive_step(1, 1'b0, 1'b0);
    checks++; if ({o_cv1, o_nx, o_ny} !== {1'b1, 3'd4, 3'd3}) begin errors++; $display("FAIL move_check got cv=%b (%0d,%0d) want 1 (4,3)", o_cv1, o_nx, o_ny); end
    checks++; if (o_map_chk !== RESET_MAP) begin errors++; $display("FAIL move_rows_in_check got %h want %h", o_map_chk, RESET_MAP); end
    checks++; if (o_map[31:24] !== 8'b0011_1000) begin errors++; $display("FAIL move_row4 got %b want 00111000", o_map[31:24]); end
    checks++; if ({o_hx, o_hy, o_done, o_cv2} !== {3'd4, 3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL move_commit got head=(%0d,%0d) done=%b cv=%b", o_hx, o_hy, o_done, o_cv2); end
    checks++; if (o_done2 !== 1'b0) begin errors++; $display("FAIL move_done_pulse got %b want 0", o_done2); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) drive_step(1, 1'b0, 1'b0);
    checks++; if ({o_nx, o_ny} !== {3'd0, 3'd3}) begin errors++; $display("FAIL wrap_next got (%0d,%0d) want (0,3)", o_nx, o_ny); end
    checks++; if ({o_hx, o_hy} !== {3'd0, 3'd3}) begin errors++; $display("FAIL wrap_head got (%0d,%0d) want (0,3)", o_hx, o_hy); end
    checks++; if (o_map[31:24] !== 8'b1000_0011) begin errors++; $display("FAIL wrap_row4 got %b want 10000011", o_map[31:24]); end
  endtask

  task automatic test_grow();
    drive_step(1, 1'b1, 1'b0);
    checks++; if (o_len !== 5'd4) begin errors++; $display("FAIL grow_len got %0d want 4", o_len); end
    checks++; if (o_map[31:24] !== 8'b0111_1000) begin errors++; $display("FAIL grow_row4 got %b want 01111000", o_map[31:24]); end
  endtask

  task automatic test_reversal();
    drive_step(3, 1'b0, 1'b0);
    checks++; if ({o_nx, o_ny} !== {3'd4, 3'd3}) begin errors++; $display("FAIL reverse_next got (%0d,%0d) want (4,3)", o_nx, o_ny); end
    drive_step(0, 1'b0, 1'b0);
    checks++; if ({o_nx, o_ny} !== {3'd4, 3'd2}) begin errors++; $display("FAIL turn_up_next got (%0d,%0d) want (4,2)", o_nx, o_ny); end
    checks++; if (o_map !== model_map()) begin errors++; $display("FAIL turn_up_map got %h want %h", o_map, model_map()); end
  endtask

  // Serpentine path that never revisits a cell; grow requested on every step.
  task automatic test_max_len();
    int path[20] = '{1,1,1,1,2,3,3,3,3,3,3,3,2,1,1,1,1,1,1,1};
    for (int i = 0; i < 20; i++) begin
      drive_step(path[i], 1'b1, 1'b0);
      checks++; if (o_map !== model_map() || o_len !== 5'(m_bx.size())) begin
        errors++; $display("FAIL maxlen_step%0d got map=%h len=%0d want map=%h len=%0d", i, o_map, o_len, model_map(), m_bx.size());
      end
    end
    checks++; if (o_len !== 5'd16) begin errors++; $display("FAIL maxlen_final got %0d want 16", o_len); end
  endtask

  task automatic test_collision();
    drive_step(1, 1'b0, 1'b1);
    checks++; if ({o_dead, o_done, o_cv2} !== 3'b100) begin errors++; $display("FAIL collide_flags got dead=%b done=%b cv=%b want 1 0 0", o_dead, o_done, o_cv2); end
    checks++; if (o_map !== RESET_MAP || o_len !== 5'd3) begin errors++; $display("FAIL collide_frozen got map=%h len=%0d", o_map, o_len); end
    @(negedge clk); step = 1'b1; dir_in = 2'b10;
    @(posedge clk); #1; step = 1'b0;
    @(posedge clk); #1;
    checks++; if ({check_valid, dead, step_done} !== 3'b010) begin errors++; $display("FAIL dead_step got cv=%b dead=%b done=%b want 0 1 0", check_valid, dead, step_done); end
    checks++; if (obs_map !== RESET_MAP) begin errors++; $display("FAIL dead_map got %h want %h", obs_map, RESET_MAP); end
    test_restart();
  endtask

  task automatic test_async_reset();
    drive_step(2, 1'b0, 1'b0);
    @(negedge clk); step = 1'b1; dir_in = 2'b10;
    @(posedge clk); #2; step = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (obs_map !== RESET_MAP || check_valid !== 1'b0) begin errors++; $display("FAIL async_reset got map=%h cv=%b", obs_map, check_valid); end
    checks++; if ({next_x, next_y, head_x, head_y, length} !== {3'd3, 3'd3, 3'd3, 3'd3, 5'd3}) begin
      errors++; $display("FAIL async_reset_pos got next=(%0d,%0d) head=(%0d,%0d) len=%0d", next_x, next_y, head_x, head_y, length);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      drive_step(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), 1'b0);
      checks++; if ({o_cv1, o_nx, o_ny} !== {1'b1, 3'(m_nx), 3'(m_ny)} || o_map_chk !== e_pre_map) begin
        errors++; $display("FAIL rand%0d_check got cv=%b (%0d,%0d) map=%h want (%0d,%0d) map=%h", n, o_cv1, o_nx, o_ny, o_map_chk, m_nx, m_ny, e_pre_map);
      end
      if (e_collide) begin
        checks++; if (o_dead !== 1'b1 || o_map !== e_pre_map || o_done !== 1'b0) begin
          errors++; $display("FAIL rand%0d_dead got dead=%b done=%b map=%h", n, o_dead, o_done, o_map);
        end
        test_restart();
      end else begin
        checks++; if (o_map !== model_map() || o_len !== 5'(m_bx.size()) || {o_hx, o_hy} !== {3'(m_bx[0]), 3'(m_by[0])} ||
                      {o_done, o_done2, o_dead} !== 3'b100) begin
          errors++; $display("FAIL rand%0d_commit got map=%h len=%0d head=(%0d,%0d) done=%b%b dead=%b want map=%h len=%0d",
                             n, o_map, o_len, o_hx, o_hy, o_done, o_done2, o_dead, model_map(), m_bx.size());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_right();
    test_wrap();
    test_restart();
    test_grow();
    test_restart();
    test_reversal();
    test_restart();
    test_max_len();
    test_restart();
    test_collision();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
